// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the CPU instruction-fetch port and the
// CPU data port. Each access is latched in IDLE, then driven to the RAM in ACCESS. Reads
// complete in RESP. Data requests win by default. A starvation counter forces an
// instruction grant after STARVE_LIMIT consecutive data grants while a fetch is pending.
//
// Ports:
//   clk, reset                 : clock (rising edge), synchronous active-high reset
//   instr_address/read         : fetch request in
//   instr_readdata/waitrequest : fetch response out
//   data_address/read/write/byteenable/writedata : load/store request in
//   data_readdata/waitrequest  : load/store response out
//   mem_address/read/write/byteenable/writedata  : RAM request out
//   mem_readdata               : RAM read data in, valid one cycle after mem_read
//
// Optional feature macro: MEM_ARB_IBUF_EN
//   Adds a one-entry instruction buffer. A fetch that hits the buffer in IDLE completes in
//   the same cycle, without a memory access.
module mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_address,
   input  logic        instr_read,
   output logic [31:0] instr_readdata,
   output logic        instr_waitrequest,
   input  logic [31:0] data_address,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [3:0]  data_byteenable,
   input  logic [31:0] data_writedata,
   output logic [31:0] data_readdata,
   output logic        data_waitrequest,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  mem_byteenable,
   output logic [31:0] mem_writedata,
   input  logic [31:0] mem_readdata
);

   localparam logic [3:0] LimitCnt = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e      r_state;
   state_e      w_state_next;

   // Latched access: address, write data, byte lanes, op and winner
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_is_write;
   logic        r_is_instr;
   logic [3:0]  r_starve_cnt;
   logic [31:0] r_instr_rdata;
   logic [31:0] r_data_rdata;

   logic        w_data_req;
   logic        w_instr_req;
   logic        w_instr_win;
   logic        w_grant;
   logic        w_data_grant;
   logic        w_instr_grant;
   logic        w_access_wr;
   logic        w_resp;
   logic        w_data_done;
   logic        w_instr_done;
   logic        w_ibuf_hit;

`ifdef MEM_ARB_IBUF_EN
   logic        r_ibuf_valid;
   logic [29:0] r_ibuf_tag;
   logic [31:0] r_ibuf_data;
   logic        w_wr_tag_match;

   // A store to the buffered word suppresses a hit in the same cycle so that stale data
   // is never returned.
   assign w_wr_tag_match = data_write && (data_address[31:2] == r_ibuf_tag);
   assign w_ibuf_hit     = !reset && (r_state == StIdle) && instr_read && r_ibuf_valid &&
                           (instr_address[31:2] == r_ibuf_tag) && !w_wr_tag_match;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ibuf_valid <= 1'b0;
         r_ibuf_tag   <= '0;
         r_ibuf_data  <= '0;
      end else if (w_resp && r_is_instr) begin
         r_ibuf_valid <= 1'b1;
         r_ibuf_tag   <= r_addr[31:2];
         r_ibuf_data  <= mem_readdata;
      end else if (w_data_grant && data_write && (data_address[31:2] == r_ibuf_tag)) begin
         r_ibuf_valid <= 1'b0;
      end
   end
`else
   assign w_ibuf_hit = 1'b0;
`endif

   // Arbitration (only meaningful in IDLE)
   assign w_data_req    = data_read || data_write;
   assign w_instr_req   = instr_read && !w_ibuf_hit;
   assign w_instr_win   = w_instr_req && (!w_data_req || (r_starve_cnt == LimitCnt));
   assign w_grant       = (r_state == StIdle) && (w_data_req || w_instr_req);
   assign w_data_grant  = w_grant && !w_instr_win;
   assign w_instr_grant = w_grant && w_instr_win;

   // Completion: writes ack in ACCESS, reads in RESP; reset suppresses any ack
   assign w_access_wr  = (r_state == StAccess) && r_is_write;
   assign w_resp       = (r_state == StResp);
   assign w_data_done  = !reset && !r_is_instr && (w_access_wr || w_resp);
   assign w_instr_done = (!reset && r_is_instr && w_resp) || w_ibuf_hit;

   assign instr_waitrequest = instr_read && !w_instr_done;
   assign data_waitrequest  = w_data_req && !w_data_done;

   assign mem_address    = r_addr;
   assign mem_writedata  = r_wdata;
   assign mem_byteenable = r_be;
   assign mem_read       = (r_state == StAccess) && !r_is_write;
   assign mem_write      = (r_state == StAccess) && r_is_write;

   // Readdata is a pass-through in RESP and holds its last value otherwise
   always_comb begin
      instr_readdata = r_instr_rdata;
      data_readdata  = r_data_rdata;
      if (!reset && w_resp) begin
         if (r_is_instr) begin
            instr_readdata = mem_readdata;
         end else begin
            data_readdata = mem_readdata;
         end
      end
`ifdef MEM_ARB_IBUF_EN
      if (w_ibuf_hit) begin
         instr_readdata = r_ibuf_data;
      end
`endif
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:   if (w_grant) w_state_next = StAccess;
         StAccess: w_state_next = r_is_write ? StIdle : StResp;
         StResp:   w_state_next = StIdle;
         default:  w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= StIdle;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_be          <= '0;
         r_is_write    <= 1'b0;
         r_is_instr    <= 1'b0;
         r_instr_rdata <= '0;
         r_data_rdata  <= '0;
      end else begin
         r_state       <= w_state_next;
         r_instr_rdata <= instr_readdata;
         r_data_rdata  <= data_readdata;
         if (w_instr_grant) begin
            // Write data is left as-is so mem_writedata keeps its last latched value
            r_addr     <= instr_address;
            r_be       <= 4'hF;
            r_is_write <= 1'b0;
            r_is_instr <= 1'b1;
         end else if (w_data_grant) begin
            r_addr     <= data_address;
            r_wdata    <= data_writedata;
            r_be       <= data_byteenable;
            r_is_write <= data_write;
            r_is_instr <= 1'b0;
         end
      end
   end

   // Starvation counter: counts data grants that pass over a pending fetch
   always_ff @(posedge clk) begin
      if (reset || !instr_read) begin
         r_starve_cnt <= '0;
      end else if (w_ibuf_hit) begin
         r_starve_cnt <= r_starve_cnt;
      end else if (w_instr_grant) begin
         r_starve_cnt <= '0;
      end else if (w_data_grant && (r_starve_cnt != 4'hF)) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

endmodule
